// File: rtl/food_placer.sv
// Food placer: draws random grid cells until it finds one the snake does not occupy.
// Gives up after MAX_TRY rejections, keeping the previous food position.
module food_placer #(
    parameter int GRID_W  = 32,
    parameter int GRID_H  = 24,
    parameter int MAX_TRY = 15
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Place,
    output logic        o_RandNeed,
    input  logic [13:0] i_RandNum,
    input  logic        i_isRanDone,
    output logic [4:0]  o_QryX,
    output logic [4:0]  o_QryY,
    output logic        o_QryVld,
    input  logic        i_QryOcc,
    output logic [4:0]  o_FoodX,
    output logic [4:0]  o_FoodY,
    output logic        o_FoodVld,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Fail
);

    typedef enum logic [2:0] {
        IDLE, REQ, WAIT, QUERY, CHECK, DONE
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] try_q, try_d;
    logic [4:0] qx_q, qx_d, qy_q, qy_d;
    logic [4:0] fx_q, fx_d, fy_q, fy_d;
    logic       fvld_q, fvld_d;
    logic       fail_q, fail_d;

    logic [4:0] rx, ry;
    logic [3:0] try_inc;
    logic       in_range, reject, exhausted;
    logic       unused_rand;

    assign rx          = i_RandNum[4:0];
    assign ry          = i_RandNum[9:5];
    assign unused_rand = ^i_RandNum[13:10];
    assign in_range    = ({1'b0, rx} < 6'(GRID_W)) &&
                         ({1'b0, ry} < 6'(GRID_H));
    assign try_inc     = try_q + 4'd1;
    assign exhausted   = (try_inc == 4'(MAX_TRY));
    assign reject      = (state_q == WAIT && i_isRanDone && !in_range) ||
                         (state_q == CHECK && i_QryOcc);

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (i_Place) state_d = REQ;
            REQ:     state_d = WAIT;
            WAIT: begin
                if (i_isRanDone) begin
                    if (in_range)       state_d = QUERY;
                    else if (exhausted) state_d = DONE;
                    else                state_d = REQ;
                end
            end
            QUERY:   state_d = CHECK;
            CHECK: begin
                if (!i_QryOcc)      state_d = DONE;
                else if (exhausted) state_d = DONE;
                else                state_d = REQ;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_RandNeed = 1'b0;
        o_QryVld   = 1'b0;
        o_Done     = 1'b0;
        o_Busy     = 1'b1;
        unique case (state_q)
            IDLE:    o_Busy     = 1'b0;
            REQ:     o_RandNeed = 1'b1;
            QUERY:   o_QryVld   = 1'b1;
            DONE:    o_Done     = 1'b1;
            default: ;
        endcase
    end

    // Datapath: candidate/query latch, retry count, food result and fail flag
    always_comb begin
        try_d  = try_q;
        qx_d   = qx_q;
        qy_d   = qy_q;
        fx_d   = fx_q;
        fy_d   = fy_q;
        fvld_d = fvld_q;
        fail_d = fail_q;
        if (state_q == IDLE && i_Place) begin
            try_d  = 4'd0;
            fvld_d = 1'b0;
            fail_d = 1'b0;
        end
        if (state_q == WAIT && i_isRanDone && in_range) begin
            qx_d = rx;
            qy_d = ry;
        end
        if (reject) begin
            try_d = try_inc;
            if (exhausted) fail_d = 1'b1;
        end
        if (state_q == CHECK && !i_QryOcc) begin
            fx_d   = qx_q;
            fy_d   = qy_q;
            fvld_d = 1'b1;
            fail_d = 1'b0;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            try_q  <= '0;
            qx_q   <= '0;
            qy_q   <= '0;
            fx_q   <= '0;
            fy_q   <= '0;
            fvld_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            try_q  <= try_d;
            qx_q   <= qx_d;
            qy_q   <= qy_d;
            fx_q   <= fx_d;
            fy_q   <= fy_d;
            fvld_q <= fvld_d;
            fail_q <= fail_d;
        end
    end

    assign o_QryX    = qx_q;
    assign o_QryY    = qy_q;
    assign o_FoodX   = fx_q;
    assign o_FoodY   = fy_q;
    assign o_FoodVld = fvld_q;
    assign o_Fail    = fail_q;

endmodule

// File: tb/tb_food_placer.sv
// Directed bench for food_placer with a two-cycle random generator model
// and a one-cycle occupancy responder fed from queues.
module tb_food_placer;

    logic        i_Clk, i_Rst, i_Place;
    logic        o_RandNeed;
    logic [13:0] i_RandNum;
    logic        i_isRanDone;
    logic [4:0]  o_QryX, o_QryY;
    logic        o_QryVld;
    logic        i_QryOcc;
    logic [4:0]  o_FoodX, o_FoodY;
    logic        o_FoodVld, o_Busy, o_Done, o_Fail;

    food_placer dut (
        .i_Clk       (i_Clk),
        .i_Rst       (i_Rst),
        .i_Place     (i_Place),
        .o_RandNeed  (o_RandNeed),
        .i_RandNum   (i_RandNum),
        .i_isRanDone (i_isRanDone),
        .o_QryX      (o_QryX),
        .o_QryY      (o_QryY),
        .o_QryVld    (o_QryVld),
        .i_QryOcc    (i_QryOcc),
        .o_FoodX     (o_FoodX),
        .o_FoodY     (o_FoodY),
        .o_FoodVld   (o_FoodVld),
        .o_Busy      (o_Busy),
        .o_Done      (o_Done),
        .o_Fail      (o_Fail)
    );

    always #5 i_Clk = ~i_Clk;

    int          errs, checks;
    int          nreq, nqry, ndone;
    logic [4:0]  lqx, lqy;
    logic [13:0] rand_q[$];
    logic        occ_q[$];
    logic        occ_dflt;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Generator: answers a request after two cycles
    always begin
        @(negedge i_Clk);
        if (o_RandNeed) begin
            nreq++;
            @(posedge i_Clk);
            #1;
            @(posedge i_Clk);
            #1;
            i_RandNum   = (rand_q.size() > 0) ? rand_q.pop_front() : 14'h3fff;
            i_isRanDone = 1'b1;
            @(posedge i_Clk);
            #1 i_isRanDone = 1'b0;
        end
    end

    // Occupancy lookup: result valid the cycle after o_QryVld
    always begin
        @(negedge i_Clk);
        if (o_QryVld) begin
            nqry++;
            lqx = o_QryX;
            lqy = o_QryY;
            @(posedge i_Clk);
            #1 i_QryOcc = (occ_q.size() > 0) ? occ_q.pop_front() : occ_dflt;
            @(posedge i_Clk);
            #1 i_QryOcc = 1'b0;
        end
    end

    always @(negedge i_Clk) if (o_Done) ndone++;

    task automatic start();
        @(posedge i_Clk);
        #1 i_Place = 1'b1;
        @(posedge i_Clk);
        #1 i_Place = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge i_Clk);
            if (o_Done) begin
                n = k;
                return;
            end
        end
        chk("done_timeout", {31'd0, o_Done}, 32'd1);
    endtask

    function automatic logic [31:0] outs();
        return {6'd0, o_RandNeed, o_QryX, o_QryY, o_QryVld, o_FoodX,
                o_FoodY, o_FoodVld, o_Busy, o_Done, o_Fail};
    endfunction

    int n, r0, q0, d0;

    initial begin
        i_Clk = 0; i_Rst = 0; i_Place = 0;
        i_RandNum = '0; i_isRanDone = 0; i_QryOcc = 0;
        occ_dflt = 0;
        errs = 0; checks = 0; nreq = 0; nqry = 0; ndone = 0;
        lqx = '0; lqy = '0;

        #12 chk("reset_outs", outs(), 32'd0);
        @(negedge i_Clk) i_Rst = 1'b1;
        repeat (2) @(negedge i_Clk);
        chk("idle_busy", {31'd0, o_Busy}, 32'd0);

        // Free cell (5,10); REQ+WAIT(2)+QUERY+CHECK = 5 edges to o_Done
        rand_q.push_back(14'h0145);
        occ_q.push_back(1'b0);
        r0 = nreq; q0 = nqry;
        start();
        wait_done(n);
        chk("t1_latency", n - 1, 32'd5);
        chk("t1_fail", {31'd0, o_Fail}, 32'd0);
        chk("t1_fvld", {31'd0, o_FoodVld}, 32'd1);
        chk("t1_food", {o_FoodX, o_FoodY}, {5'd5, 5'd10});
        chk("t1_nreq", nreq - r0, 32'd1);
        chk("t1_nqry", nqry - q0, 32'd1);
        chk("t1_qry", {lqx, lqy}, {5'd5, 5'd10});
        @(negedge i_Clk);
        chk("t1_idle", {o_Busy, o_Done, o_QryVld}, 3'b000);
        chk("t1_qhold", {o_QryX, o_QryY}, {5'd5, 5'd10});

        // y=25 out of range, then (2,3) free
        rand_q.push_back(14'h0323);
        rand_q.push_back(14'h0062);
        occ_q.push_back(1'b0);
        r0 = nreq; q0 = nqry;
        start();
        wait_done(n);
        chk("t2_nreq", nreq - r0, 32'd2);
        chk("t2_nqry", nqry - q0, 32'd1);
        chk("t2_food", {o_FoodX, o_FoodY}, {5'd2, 5'd3});
        chk("t2_fail", {31'd0, o_Fail}, 32'd0);

        // (7,7) occupied, (8,7) free
        rand_q.push_back(14'h00e7);
        rand_q.push_back(14'h00e8);
        occ_q.push_back(1'b1);
        occ_q.push_back(1'b0);
        r0 = nreq; q0 = nqry;
        start();
        wait_done(n);
        chk("t3_nqry", nqry - q0, 32'd2);
        chk("t3_food", {o_FoodX, o_FoodY}, {5'd8, 5'd7});
        chk("t3_fvld", {o_FoodVld, o_Fail}, 2'b10);

        // Every candidate occupied; upper bits set must be ignored
        occ_dflt = 1'b1;
        for (int i = 0; i < 15; i++) rand_q.push_back({4'hf, 5'd1, 5'(i)});
        r0 = nreq; q0 = nqry;
        start();
        wait_done(n);
        chk("t4_nqry", nqry - q0, 32'd15);
        chk("t4_nreq", nreq - r0, 32'd15);
        chk("t4_fail", {31'd0, o_Fail}, 32'd1);
        chk("t4_fvld", {31'd0, o_FoodVld}, 32'd0);
        chk("t4_food", {o_FoodX, o_FoodY}, {5'd8, 5'd7});
        chk("t4_lastq", {lqx, lqy}, {5'd14, 5'd1});
        @(negedge i_Clk);
        chk("t4_failhold", {o_Fail, o_Busy, o_Done}, 3'b100);
        occ_dflt = 1'b0;

        // Reset while in WAIT
        rand_q.push_back(14'h0001);
        d0 = ndone;
        start();
        @(negedge i_Clk);
        @(negedge i_Clk);
        chk("t5_inwait", {o_Busy, o_RandNeed, o_QryVld}, 3'b100);
        i_Rst = 1'b0;
        #1 chk("t5_rst_outs", outs(), 32'd0);
        repeat (4) @(negedge i_Clk);
        chk("t5_rst_hold", outs(), 32'd0);
        i_Rst = 1'b1;
        repeat (3) @(negedge i_Clk);
        chk("t5_no_done", ndone - d0, 32'd0);
        rand_q.push_back(14'h0084);
        occ_q.push_back(1'b0);
        start();
        wait_done(n);
        chk("t5_food", {o_FoodX, o_FoodY}, {5'd4, 5'd4});
        chk("t5_ok", {o_FoodVld, o_Fail}, 2'b10);
        @(negedge i_Clk);
        chk("t5_ndone", ndone - d0, 32'd1);

        // i_Place raised in CHECK and held through DONE
        rand_q.push_back(14'h0041);
        rand_q.push_back(14'h0083);
        occ_q.push_back(1'b0);
        occ_q.push_back(1'b0);
        r0 = nreq; d0 = ndone;
        start();
        for (int k = 0; k < 50; k++) begin
            @(negedge i_Clk);
            if (o_QryVld) break;
        end
        @(negedge i_Clk);
        i_Place = 1'b1;
        wait_done(n);
        chk("t6_nreq1", nreq - r0, 32'd1);
        chk("t6_food1", {o_FoodX, o_FoodY}, {5'd1, 5'd2});
        @(negedge i_Clk);
        chk("t6_idle", {31'd0, o_Busy}, 32'd0);
        chk("t6_ndone1", ndone - d0, 32'd1);
        @(posedge i_Clk);
        #1 i_Place = 1'b0;
        chk("t6_restart", {o_Busy, o_RandNeed}, 2'b11);
        wait_done(n);
        @(negedge i_Clk);
        chk("t6_ndone2", ndone - d0, 32'd2);
        chk("t6_nreq2", nreq - r0, 32'd2);
        chk("t6_food2", {o_FoodX, o_FoodY}, {5'd3, 5'd4});
        chk("t6_ok", {o_FoodVld, o_Fail}, 2'b10);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/food_placer.md
FOOD_PLACER -- requirements
Module: food_placer

Interface
REQ-001 Parameter GRID_W, default 32, SHALL set grid columns (1..32); legal x = 0..GRID_W-1.
REQ-002 Parameter GRID_H, default 24, SHALL set grid rows (1..32); legal y = 0..GRID_H-1.
REQ-003 Parameter MAX_TRY, default 15, SHALL set rejections allowed before failure (1..15).
REQ-004 i_Clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 i_Rst  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 i_Place  in  1  SHALL request one food placement; sampled only in IDLE.
REQ-007 o_RandNeed  out  1  SHALL be the one-cycle request to the upstream random-number generator.
REQ-008 i_RandNum  in  14  SHALL be the random value; valid while i_isRanDone=1.
REQ-009 i_isRanDone  in  1  SHALL qualify i_RandNum.
REQ-010 o_QryX / o_QryY  out  5 / 5  SHALL be the candidate cell sent to the occupancy lookup.
REQ-011 o_QryVld  out  1  SHALL qualify o_QryX/o_QryY for one cycle.
REQ-012 i_QryOcc  in  1  SHALL be the occupancy result, valid exactly one cycle after o_QryVld (1 = snake on cell).
REQ-013 o_FoodX / o_FoodY  out  5 / 5  SHALL hold the placed food cell.
REQ-014 o_FoodVld  out  1  SHALL be high while o_FoodX/o_FoodY hold a successful placement.
REQ-015 o_Busy  out  1  SHALL be high in every state except IDLE.
REQ-016 o_Done  out  1  SHALL pulse for one cycle when a placement attempt ends.
REQ-017 o_Fail  out  1  SHALL be valid with o_Done; 1 = retries exhausted.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, QUERY, CHECK, DONE.
REQ-019 IDLE: i_Place=1 -> REQ; try counter cleared; o_FoodVld cleared on the same edge.
REQ-020 REQ: o_RandNeed=1 for exactly this cycle -> WAIT.
REQ-021 WAIT: stay until i_isRanDone=1; then capture cand_x=i_RandNum[4:0], cand_y=i_RandNum[9:5]; bits 13:10 ignored.
REQ-022 WAIT range check: cand_x>=GRID_W or cand_y>=GRID_H SHALL count one rejection; no modulo folding.
REQ-023 In-range candidate -> QUERY; o_QryX/o_QryY SHALL present cand_x/cand_y registered, o_QryVld=1 for that single cycle -> CHECK.
REQ-024 CHECK: i_QryOcc=0 -> load o_FoodX/o_FoodY=candidate, o_FoodVld=1, o_Fail=0 -> DONE.
REQ-025 CHECK: i_QryOcc=1 counts one rejection.
REQ-026 Rejection handling: counter increments (4-bit); new count==MAX_TRY -> DONE with o_Fail=1; otherwise -> REQ.
REQ-027 On failure o_FoodX/o_FoodY SHALL retain previous values; o_FoodVld stays 0.
REQ-028 DONE: o_Done=1 one cycle -> IDLE; o_Fail held until next accepted i_Place.
REQ-029 i_Place while o_Busy=1 SHALL be ignored, not queued.
REQ-030 i_isRanDone outside WAIT and i_QryOcc outside CHECK SHALL be ignored.
REQ-031 Best-case latency, i_Place edge to o_Done high: REQ(1)+WAIT(n)+QUERY(1)+CHECK(1), with n = generator response cycles (2 for a request-run-done generator).
REQ-032 o_QryX/o_QryY SHALL hold last query between queries; o_QryVld=0 otherwise.

Reset
REQ-033 i_Rst=0 SHALL, asynchronously and at any state: FSM->IDLE, try counter=0, all outputs 0 (o_RandNeed, o_QryX, o_QryY, o_QryVld, o_FoodX, o_FoodY, o_FoodVld, o_Busy, o_Done, o_Fail).
REQ-034 Reset mid-placement SHALL abandon the attempt without o_Done; first i_Place after release starts a fresh attempt.

Verification
REQ-035 Place, i_RandNum=14'h0145 (x=5,y=10), i_QryOcc=0 -> one o_RandNeed pulse, o_QryVld with (5,10), o_Done=1, o_Fail=0, o_FoodVld=1, food=(5,10).
REQ-036 Out of range: first i_RandNum y=25 (14'h0323), second 14'h0062 (x=2,y=3) free -> two o_RandNeed pulses, one o_QryVld, food=(2,3).
REQ-037 Occupied retry: first candidate (7,7) i_QryOcc=1, second (8,7) i_QryOcc=0 -> two queries, food=(8,7), o_Fail=0.
REQ-038 Exhaustion: MAX_TRY=15, every candidate occupied -> exactly 15 o_QryVld pulses, o_Done with o_Fail=1, o_FoodVld=0, previous food coordinates unchanged.
REQ-039 Reset in WAIT, then i_Place -> all outputs 0 during reset, no o_Done for the aborted attempt, new attempt completes normally.
REQ-040 i_Place pulsed during CHECK and held high through DONE -> exactly one attempt completes, then a second starts from IDLE.
